// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: one outstanding imem request, a small PC-tagged
// instruction buffer, and branch/jump redirect with discard of in-flight responses.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [5:0]  opcode,
  output logic [5:0]  funct
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DRAIN} state_e;

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       req_pc_q, req_pc_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [31:0]       buf_instr_q [FIFO_DEPTH];
  logic [31:0]       buf_pc_q    [FIFO_DEPTH];
  logic              accept, push, pop, head_vld;
  logic [31:0]       head_instr;
  logic              unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // imem_req is gated by rst_n so the request is low while reset is held.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    push       = 1'b0;
    imem_req   = rst_n && (state_q == S_FETCH) && (count_q < DEPTH_C) && !redirect_valid;
    accept     = imem_req && imem_ready;
    case (state_q)
      S_FETCH: begin
        if (accept) begin
          state_d    = S_WAIT;
          fetch_pc_d = fetch_pc_q + 32'd4;
          req_pc_d   = fetch_pc_q;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_FETCH;
          push    = !redirect_valid;
        end else if (redirect_valid) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (redirect_valid) fetch_pc_d = {redirect_pc[31:2], 2'b00};
  end

  assign imem_addr = fetch_pc_q;
  assign head_vld  = (count_q != '0);
  assign pop       = head_vld && instr_ready && !redirect_valid;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (redirect_valid) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W + 1)'(1);
        2'b01:   count_d = count_q - (PTR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Buffer contents need no reset: an empty buffer masks the head to zero.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr_q[wr_ptr_q] <= imem_rdata;
      buf_pc_q[wr_ptr_q]    <= req_pc_q;
    end
  end

  assign head_instr  = head_vld ? buf_instr_q[rd_ptr_q] : 32'd0;
  assign instr_valid = head_vld;
  assign instr       = head_instr;
  assign instr_pc    = head_vld ? buf_pc_q[rd_ptr_q] : 32'd0;
  assign opcode      = head_instr[31:26];
  assign funct       = head_instr[5:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, backpressure, redirects,
// PC wrap and asynchronous reset with hand-computed expectations.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [5:0]  opcode;
  logic [5:0]  funct;

  int          n_cmp = 0;
  int          n_err = 0;
  bit          pend;
  bit          auto_resp;
  logic [31:0] pend_addr;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .opcode(opcode), .funct(funct)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h012A_4020 + a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock: sample acceptance before the edge, then play the memory side.
  task automatic tick();
    bit          acc;
    logic [31:0] a;
    #1;
    acc = imem_req && imem_ready;
    a   = imem_addr;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (acc) begin
      pend      = 1'b1;
      pend_addr = a;
    end
    if (pend && auto_resp) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word(pend_addr);
      pend        = 1'b0;
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_vld"},   {31'd0, instr_valid}, 32'd1);
    chk({tag, "_pc"},    instr_pc, pc);
    chk({tag, "_instr"}, instr, word(pc));
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    pend = 1'b0; auto_resp = 1'b1; pend_addr = '0;
    #1;
    chk("rst_req",    {31'd0, imem_req}, 32'd0);
    chk("rst_addr",   imem_addr, 32'h0);
    chk("rst_vld",    {31'd0, instr_valid}, 32'd0);
    chk("rst_instr",  instr, 32'h0);
    chk("rst_pc",     instr_pc, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Sequential fetch with immediate consumption
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t1_req",  {31'd0, imem_req}, 32'd1);
      chk("t1_addr", imem_addr, 32'(4 * k));
      tick();
      chk("t1_wait_req", {31'd0, imem_req}, 32'd0);
      tick();
      chk_head("t1_head", 32'(4 * k));
    end
    chk("t1_opc", {26'd0, opcode}, 32'h0);   // head is pc 8: word 0x012A4028
    chk("t1_fn",  {26'd0, funct},  32'h28);

    // Backpressure fills the buffer, then drains in order
    instr_ready = 1'b0;
    tick();
    tick();
    chk("t2_full_req", {31'd0, imem_req}, 32'd0);
    tick();
    tick();
    chk("t2_hold_req", {31'd0, imem_req}, 32'd0);
    chk_head("t2_hold", 32'h8);
    instr_ready = 1'b1;
    tick();
    chk_head("t2_pop1", 32'hC);
    chk("t2_resume_req",  {31'd0, imem_req}, 32'd1);
    chk("t2_resume_addr", imem_addr, 32'h10);

    // Redirect while the request for 0x10 is outstanding
    auto_resp = 1'b0;
    tick();
    chk("t3_empty", {31'd0, instr_valid}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    #1 chk("t3_req_forced", {31'd0, imem_req}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    chk("t3_drain_req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = word(pend_addr); pend = 1'b0;
    tick();
    auto_resp = 1'b1;
    chk("t3_discard_vld", {31'd0, instr_valid}, 32'd0);
    chk("t3_req",  {31'd0, imem_req}, 32'd1);
    chk("t3_addr", imem_addr, 32'h100);
    tick();
    tick();
    chk_head("t3_head", 32'h100);

    // Redirect coincident with a response and a pop
    instr_ready = 1'b0;
    tick();
    chk("t4_rvalid_up", {31'd0, imem_rvalid}, 32'd1);
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    chk("t4_vld",   {31'd0, instr_valid}, 32'd0);
    chk("t4_instr", instr, 32'h0);
    chk("t4_addr",  imem_addr, 32'h200);
    tick();
    chk("t4_still_empty", {31'd0, instr_valid}, 32'd0);
    tick();
    chk_head("t4_head", 32'h200);

    // Redirect to the top word, fetch wraps to zero
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    chk("t5_vld", {31'd0, instr_valid}, 32'd0);
    tick();
    tick();
    chk_head("t5_top", 32'hFFFF_FFFC);
    chk("t5_addr_wrap", imem_addr, 32'h0);
    tick();
    tick();
    chk_head("t5_wrap", 32'h0);

    // Asynchronous reset while waiting with the buffer fully committed
    instr_ready = 1'b0; auto_resp = 1'b0;
    tick();
    chk_head("t6_pre", 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_vld",   {31'd0, instr_valid}, 32'd0);
    chk("t6_req",   {31'd0, imem_req}, 32'd0);
    chk("t6_addr",  imem_addr, 32'h0);
    chk("t6_instr", instr, 32'h0);
    chk("t6_pc",    instr_pc, 32'h0);
    pend = 1'b0; imem_rvalid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1; auto_resp = 1'b1; instr_ready = 1'b1;
    #1;
    chk("t6_req_after", {31'd0, imem_req}, 32'd1);
    chk("t6_addr_after", imem_addr, 32'h0);
    tick();
    tick();
    chk_head("t6_head", 32'h0);
    chk("t6_fn", {26'd0, funct}, 32'h20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
